// File: rtl/muldiv_pkg.sv
// Shared definitions for the sequential multiply/divide unit: op codes,
// FSM states, iteration count and small op-decode helpers.
package muldiv_pkg;

  localparam int ITER  = 32;
  localparam int CNT_W = 5;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITER - 1);

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10
  } state_e;

  function automatic logic opIsDiv(input op_e opSel);
    return (opSel == OP_DIVU) || (opSel == OP_DIV);
  endfunction

  function automatic logic opIsSigned(input op_e opSel);
    return (opSel == OP_MULT) || (opSel == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the datapath: shift-add multiply step or restoring
// divide step on the 64-bit accumulator {upper, lower}.
module muldiv_step
  import muldiv_pkg::*;
(
  input  logic        isDiv_i,
  input  logic [63:0] acc_i,
  input  logic [31:0] operand_i,
  output logic [63:0] acc_o
);

  logic [32:0] addSum;
  logic [32:0] remCand;
  logic [32:0] diff;

  // Divide: diff[32] is the borrow, since a partial remainder stays below
  // twice the divisor and a non-negative difference always fits in 32 bits.
  always_comb begin
    addSum  = {1'b0, acc_i[63:32]} + (acc_i[0] ? {1'b0, operand_i} : 33'd0);
    remCand = {acc_i[63:32], acc_i[31]};
    diff    = remCand - {1'b0, operand_i};
    acc_o   = {addSum, acc_i[31:1]};
    if (isDiv_i) begin
      if (!diff[32]) begin
        acc_o = {diff[31:0], acc_i[30:0], 1'b1};
      end else begin
        acc_o = {remCand[31:0], acc_i[30:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Sequential 32-bit MULT/MULTU/DIV/DIVU unit with HI/LO registers,
// fixed 34-cycle latency and MTHI/MTLO write ports.
module muldiv_seq
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        wr_hi,
  input  logic        wr_lo,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      acc_q, acc_d;
  logic [31:0]      opnd_q, opnd_d;
  logic             isDiv_q, isDiv_d;
  logic             negRes_q, negRes_d;
  logic             negRem_q, negRem_d;
  logic             divZero_q, divZero_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  op_e         opSel;
  logic        aNeg, bNeg;
  logic [31:0] aMag, bMag;
  logic [63:0] stepAcc;
  logic [63:0] prodFix;
  logic [31:0] quotFix, remFix;

  muldiv_step u_step (
    .isDiv_i   (isDiv_q),
    .acc_i     (acc_q),
    .operand_i (opnd_q),
    .acc_o     (stepAcc)
  );

  always_comb begin
    opSel = op_e'(op);
    aNeg  = opIsSigned(opSel) & a[31];
    bNeg  = opIsSigned(opSel) & b[31];
    aMag  = aNeg ? (~a + 32'd1) : a;
    bMag  = bNeg ? (~b + 32'd1) : b;
  end

  always_comb begin
    prodFix = negRes_q ? (~acc_q + 64'd1) : acc_q;
    quotFix = negRes_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
    remFix  = negRem_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
  end

  // Next-state and register updates; MTHI/MTLO only land in IDLE without start.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    isDiv_d   = isDiv_q;
    negRes_d  = negRes_q;
    negRem_d  = negRem_q;
    divZero_d = divZero_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dbz_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_RUN;
          cnt_d     = '0;
          acc_d     = {32'd0, aMag};
          opnd_d    = bMag;
          isDiv_d   = opIsDiv(opSel);
          negRes_d  = aNeg ^ bNeg;
          negRem_d  = aNeg;
          divZero_d = opIsDiv(opSel) && (b == 32'd0);
        end else begin
          if (wr_hi) hi_d = wdata;
          if (wr_lo) lo_d = wdata;
        end
      end
      S_RUN: begin
        acc_d = stepAcc;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        done_d  = 1'b1;
        dbz_d   = divZero_q;
        if (isDiv_q) begin
          hi_d = remFix;
          lo_d = divZero_q ? 32'hFFFF_FFFF : quotFix;
        end else begin
          hi_d = prodFix[63:32];
          lo_d = prodFix[31:0];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      isDiv_q   <= 1'b0;
      negRes_q  <= 1'b0;
      negRem_q  <= 1'b0;
      divZero_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      isDiv_q   <= isDiv_d;
      negRes_q  <= negRes_d;
      negRem_q  <= negRem_d;
      divZero_q <= divZero_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: expected results are queued at start and
// compared when done pulses, together with the exact completion cycle.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, wr_hi, wr_lo;
  logic [1:0]  op;
  logic [31:0] a, b, wdata;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int unsigned doneCyc;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          passes = 0;

  muldiv_seq dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .wr_hi       (wr_hi),
    .wr_lo       (wr_lo),
    .wdata       (wdata),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clk = ~clk;

  // Cycle index advances on every rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
  endtask

  // Reference behaviour computed with wide native arithmetic.
  function automatic exp_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t   e;
    longint sp, sq, sr;
    logic [63:0] up;
    e.dbz = 1'b0;
    e.doneCyc = 0;
    case (o)
      2'b00: begin
        up = {32'd0, x} * {32'd0, y};
        e.hi = up[63:32];
        e.lo = up[31:0];
      end
      2'b01: begin
        sp = longint'($signed(x)) * longint'($signed(y));
        e.hi = sp[63:32];
        e.lo = sp[31:0];
      end
      2'b10: begin
        if (y == 0) begin
          e.hi = x; e.lo = 32'hFFFF_FFFF; e.dbz = 1'b1;
        end else begin
          e.hi = x % y; e.lo = x / y;
        end
      end
      default: begin
        if (y == 0) begin
          e.hi = x; e.lo = 32'hFFFF_FFFF; e.dbz = 1'b1;
        end else begin
          sq = longint'($signed(x)) / longint'($signed(y));
          sr = longint'($signed(x)) % longint'($signed(y));
          e.hi = sr[31:0];
          e.lo = sq[31:0];
        end
      end
    endcase
    return e;
  endfunction

  // Called just after a falling edge; start is sampled at the next rising edge.
  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                               input logic [31:0] eHi, input logic [31:0] eLo, input logic eDbz);
    exp_t e;
    start = 1'b1; op = o; a = x; b = y;
    e.hi = eHi; e.lo = eLo; e.dbz = eDbz; e.doneCyc = cyc + 34;
    sb.push_back(e);
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  task automatic applyModelled(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    e = model(o, x, y);
    applyStimulus(o, x, y, e.hi, e.lo, e.dbz);
  endtask

  task automatic waitCycle(input int unsigned target);
    while (cyc < target) begin
      @(negedge clk); #1;
    end
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 100 && sb.size() != 0; i++) begin
      @(negedge clk); #1;
    end
    if (sb.size() != 0) begin
      checkOutput("done_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  // Output side of the scoreboard: every done pulse must match the oldest entry.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done) begin
      if (sb.size() == 0) begin
        checkOutput("spurious_done", {31'd0, done}, 32'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("done_cycle", 32'(cyc), 32'(e.doneCyc));
        checkOutput("hi", hi, e.hi);
        checkOutput("lo", lo, e.lo);
        checkOutput("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dbz});
      end
    end
  end

  initial begin
    int unsigned t0;
    logic [31:0] prevHi, prevLo, ra, rb;
    logic [1:0]  rop;

    // Reset held together with start and writes: reset must win.
    rst = 1'b1; start = 1'b1; op = 2'b00; a = 32'd5; b = 32'd5;
    wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'hA5A5_A5A5;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    checkOutput("rst_hi", hi, 32'd0);
    checkOutput("rst_lo", lo, 32'd0);
    #1;
    rst = 1'b0; start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
    @(negedge clk); #1;

    // MULTU with busy window checks, then a start in the done cycle.
    t0 = cyc;
    applyStimulus(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    checkOutput("busy_c1", {31'd0, busy}, 32'd1);
    waitCycle(t0 + 33);
    checkOutput("busy_c33", {31'd0, busy}, 32'd1);
    checkOutput("done_c33", {31'd0, done}, 32'd0);
    waitCycle(t0 + 34);
    checkOutput("busy_c34", {31'd0, busy}, 32'd0);
    applyStimulus(OP_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    waitIdle();

    applyStimulus(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    waitIdle();
    applyStimulus(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
    waitIdle();
    applyStimulus(OP_DIVU, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1);
    waitIdle();
    applyStimulus(OP_DIV, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b1);
    waitIdle();

    // Start and MTHI issued while busy are both ignored.
    prevHi = hi;
    t0 = cyc;
    applyStimulus(OP_DIVU, 32'd1000, 32'd7, 32'd6, 32'd142, 1'b0);
    waitCycle(t0 + 5);
    start = 1'b1; op = OP_MULTU; a = 32'd3; b = 32'd3;
    @(negedge clk); #1;
    start = 1'b0; wr_hi = 1'b1; wdata = 32'hDEAD_BEEF;
    @(negedge clk); #1;
    wr_hi = 1'b0;
    checkOutput("hi_hold_busy", hi, prevHi);
    waitIdle();

    // MTHI while idle lands one cycle later and leaves LO alone.
    prevLo = lo;
    wr_hi = 1'b1; wdata = 32'hCAFE_F00D;
    @(negedge clk);
    checkOutput("mthi_hi", hi, 32'hCAFE_F00D);
    checkOutput("mthi_lo", lo, prevLo);
    #1 wr_hi = 1'b0;

    // Start and MTLO together: start wins.
    prevLo = lo;
    wr_lo = 1'b1; wdata = 32'h0000_5555;
    applyStimulus(OP_MULTU, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0);
    wr_lo = 1'b0;
    checkOutput("start_wins_lo", lo, prevLo);
    checkOutput("start_wins_busy", {31'd0, busy}, 32'd1);
    waitIdle();

    applyModelled(OP_DIV, 32'd100, 32'hFFFF_FFF9);
    waitIdle();

    for (int i = 0; i < 8; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom();
      rb  = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom();
      if (i == 3) rb = 32'd13;
      applyModelled(rop, ra, rb);
      waitIdle();
    end

    // Reset in cycle 10 of a DIVU aborts it without a done pulse.
    t0 = cyc;
    applyStimulus(OP_DIVU, 32'd5000, 32'd3, 32'd2, 32'd1666, 1'b0);
    waitCycle(t0 + 10);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_done", {31'd0, done}, 32'd0);
    checkOutput("abort_hi", hi, 32'd0);
    checkOutput("abort_lo", lo, 32'd0);
    #1;
    rst = 1'b0; wr_lo = 1'b1; wdata = 32'h0000_1234;
    @(negedge clk);
    checkOutput("mtlo_after_abort", lo, 32'h0000_1234);
    #1 wr_lo = 1'b0;
    repeat (40) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have clk, input, 1: single clock; all state updates on its rising edge.
REQ-002 SHALL have rst, input, 1: reset, synchronous, active-high.
REQ-003 SHALL have start, input, 1: request a new operation; sampled only when busy=0.
REQ-004 SHALL have op, input, 2: operation select, 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-005 SHALL have a, input, 32: multiplicand or dividend.
REQ-006 SHALL have b, input, 32: multiplier or divisor.
REQ-007 SHALL have wr_hi, input, 1: MTHI write enable.
REQ-008 SHALL have wr_lo, input, 1: MTLO write enable.
REQ-009 SHALL have wdata, input, 32: data for MTHI/MTLO.
REQ-010 SHALL have busy, output, 1: high while an operation is in flight; pipeline stall source.
REQ-011 SHALL have done, output, 1: one-cycle pulse; hi/lo hold the new result.
REQ-012 SHALL have div_by_zero, output, 1: pulses with done when a divide had b=0.
REQ-013 SHALL have hi, output, 32: HI register, read by MFHI.
REQ-014 SHALL have lo, output, 32: LO register, read by MFLO.

Function
REQ-015 SHALL implement FSM states IDLE -> RUN -> FIX -> IDLE; busy=1 exactly when state is not IDLE.
REQ-016 SHALL leave IDLE for RUN on start=1, latching op, |a|, |b| and sign flags; signed ops take two's-complement magnitudes.
REQ-017 SHALL stay in RUN for exactly 32 cycles: shift-add multiply or restoring divide, one bit per cycle, 5-bit iteration counter.
REQ-018 SHALL spend 1 cycle in FIX: negate the product if the operand signs differ; negate the quotient if the signs differ and the remainder if a was negative; then write hi/lo.
REQ-019 SHALL provide fixed latency: start sampled in cycle 0, busy high in cycles 1-33, done and valid hi/lo in cycle 34, in which state is IDLE.
REQ-020 SHALL place the 64-bit product in hi (upper) and lo (lower); for divides, quotient in lo and remainder in hi.
REQ-021 SHALL, for a divide with b=0, still take the full 34 cycles and give lo=0xFFFFFFFF and hi=a (unmodified), and pulse div_by_zero.
REQ-022 SHALL give lo=0x80000000 and hi=0 for DIV 0x80000000 / 0xFFFFFFFF, with no flag.
REQ-023 SHALL ignore start while busy=1; a start in the done cycle is accepted.
REQ-024 SHALL let wr_hi/wr_lo update hi/lo in the next cycle when busy=0 and start=0.
REQ-025 SHALL ignore wr_hi/wr_lo when busy=1 or when start=1 in the same cycle (start wins).
REQ-026 SHALL hold hi/lo stable except on the FIX write and accepted wr_hi/wr_lo writes.

Reset
REQ-027 SHALL, on rst=1 at any clock edge (including mid-RUN/FIX), go to IDLE with hi=0, lo=0, busy=0, done=0, div_by_zero=0, counter=0; no done pulse for the aborted operation.
REQ-028 SHALL give rst priority over start and writes in the same cycle.

Structure
REQ-029 SHALL take op encodings, state encodings and ITER=32 from a shared package used by the decoder and control unit.
REQ-030 SHALL put the per-iteration add/subtract-and-shift datapath in one combinational sub-module, muldiv_step; FSM, counter and HI/LO live in muldiv_seq.

Verification
REQ-031 SHALL test MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> done in cycle 34, hi=0xFFFFFFFE, lo=0x00000001.
REQ-032 SHALL test MULT a=0xFFFFFFFD (-3) b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-033 SHALL test DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-034 SHALL test DIVU a=100 b=0 -> cycle 34 done=1, div_by_zero=1, hi=0x00000064, lo=0xFFFFFFFF.
REQ-035 SHALL test start with op=MULTU at cycle 5 while busy, then wr_hi=1 while busy -> both ignored; the first result is unchanged.
REQ-036 SHALL test rst=1 at cycle 10 of a DIVU -> next cycle busy=0, hi=lo=0, no done; then MTLO 0x1234 -> lo=0x00001234 one cycle later.
